// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: request-to-send, 11-bit frame on device clocks, ACK check.
// Optional build macro PS2_HOST_TX_RETRY_EN: retry a failed frame up to two more times before reporting.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int REQ_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_err,
  output logic [1:0] err_code,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);

  localparam int MAX_A = (INHIBIT_CYCLES > REQ_CYCLES) ? INHIBIT_CYCLES : REQ_CYCLES;
  localparam int MAX_C = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
  localparam int CNT_W = $clog2(MAX_C + 1);
  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] REQ_LAST = CNT_W'(REQ_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_REQ, S_SEND, S_ACK, S_ACKED, S_FAIL
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       bit_idx_q, bit_idx_d;
  logic [8:0]       frame_q, frame_d;
  logic             tx_ready_q, tx_ready_d;
  logic             tx_done_q, tx_done_d;
  logic             tx_err_q, tx_err_d;
  logic [1:0]       err_code_q, err_code_d;
  logic             clk_oe_q, clk_oe_d;
  logic             dat_oe_q, dat_oe_d;
  logic [1:0]       clk_sync_q, clk_sync_d;
  logic [1:0]       dat_sync_q, dat_sync_d;
  logic             clk_prev_q, clk_prev_d;
`ifdef PS2_HOST_TX_RETRY_EN
  logic [1:0]       retry_q, retry_d;
`endif

  logic       clk_s, dat_s, fe;
  logic       fail_now;
  logic [1:0] fail_code;

  assign clk_s = clk_sync_q[1];
  assign dat_s = dat_sync_q[1];
  assign fe    = clk_prev_q & ~clk_s;

  always_comb begin
    clk_sync_d = {clk_sync_q[0], ps2_clk_in};
    dat_sync_d = {dat_sync_q[0], ps2_dat_in};
    clk_prev_d = clk_s;
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    frame_d    = frame_q;
    tx_ready_d = tx_ready_q;
    tx_done_d  = 1'b0;
    tx_err_d   = 1'b0;
    err_code_d = err_code_q;
    clk_oe_d   = clk_oe_q;
    dat_oe_d   = dat_oe_q;
    fail_now   = 1'b0;
    fail_code  = 2'b00;
`ifdef PS2_HOST_TX_RETRY_EN
    retry_d    = retry_q;
`endif

    // One counter serves both phase timing and the inter-edge watchdog.
    if (state_q == S_SEND || state_q == S_ACK || state_q == S_ACKED) begin
      if (fe) begin
        cnt_d = '0;
      end else if (cnt_q == TO_LAST) begin
        fail_now  = 1'b1;
        fail_code = 2'b01;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    case (state_q)
      S_IDLE: begin
        clk_oe_d   = 1'b0;
        dat_oe_d   = 1'b0;
        tx_ready_d = 1'b1;
        if (tx_valid && tx_ready_q) begin
          frame_d    = {~^tx_data, tx_data};
          err_code_d = 2'b00;
          cnt_d      = '0;
          clk_oe_d   = 1'b1;
          tx_ready_d = 1'b0;
          state_d    = S_INHIBIT;
`ifdef PS2_HOST_TX_RETRY_EN
          retry_d    = 2'd0;
`endif
        end
      end
      S_INHIBIT: begin
        if (cnt_q == INH_LAST) begin
          cnt_d    = '0;
          dat_oe_d = 1'b1;
          state_d  = S_REQ;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_REQ: begin
        if (cnt_q == REQ_LAST) begin
          cnt_d     = '0;
          clk_oe_d  = 1'b0;
          bit_idx_d = 4'd0;
          state_d   = S_SEND;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_SEND: begin
        if (fe) begin
          if (bit_idx_q == 4'd9) begin
            dat_oe_d = 1'b0;
            state_d  = S_ACK;
          end else begin
            dat_oe_d  = ~frame_q[bit_idx_q];
            bit_idx_d = bit_idx_q + 4'd1;
          end
        end
      end
      S_ACK: begin
        if (fe) begin
          if (!dat_s) begin
            state_d = S_ACKED;
          end else begin
            fail_now  = 1'b1;
            fail_code = 2'b10;
          end
        end
      end
      S_ACKED: begin
        if (clk_s && dat_s) begin
          tx_ready_d = 1'b1;
          tx_done_d  = 1'b1;
          state_d    = S_IDLE;
        end
      end
      S_FAIL: begin
        clk_oe_d   = 1'b0;
        dat_oe_d   = 1'b0;
        tx_ready_d = 1'b1;
        tx_err_d   = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (fail_now) begin
      err_code_d = fail_code;
      clk_oe_d   = 1'b0;
      dat_oe_d   = 1'b0;
      tx_done_d  = 1'b0;
      tx_ready_d = 1'b0;
      state_d    = S_FAIL;
`ifdef PS2_HOST_TX_RETRY_EN
      if (retry_q != 2'd2) begin
        retry_d  = retry_q + 2'd1;
        cnt_d    = '0;
        clk_oe_d = 1'b1;
        state_d  = S_INHIBIT;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= 4'd0;
      frame_q    <= 9'd0;
      tx_ready_q <= 1'b1;
      tx_done_q  <= 1'b0;
      tx_err_q   <= 1'b0;
      err_code_q <= 2'b00;
      clk_oe_q   <= 1'b0;
      dat_oe_q   <= 1'b0;
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      clk_prev_q <= 1'b1;
`ifdef PS2_HOST_TX_RETRY_EN
      retry_q    <= 2'd0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      frame_q    <= frame_d;
      tx_ready_q <= tx_ready_d;
      tx_done_q  <= tx_done_d;
      tx_err_q   <= tx_err_d;
      err_code_q <= err_code_d;
      clk_oe_q   <= clk_oe_d;
      dat_oe_q   <= dat_oe_d;
      clk_sync_q <= clk_sync_d;
      dat_sync_q <= dat_sync_d;
      clk_prev_q <= clk_prev_d;
`ifdef PS2_HOST_TX_RETRY_EN
      retry_q    <= retry_d;
`endif
    end
  end

  assign tx_ready   = tx_ready_q;
  assign tx_done    = tx_done_q;
  assign tx_err     = tx_err_q;
  assign err_code   = err_code_q;
  assign ps2_clk_oe = clk_oe_q;
  assign ps2_dat_oe = dat_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: behavioural PS/2 device on open-drain lines, frame-bit scoreboard.
module tb_ps2_host_tx;

  localparam int INH  = 50;
  localparam int RQ   = 16;
  localparam int TO   = 3000;
  localparam int HALF = 40;
`ifdef PS2_HOST_TX_RETRY_EN
  localparam int FAIL_ATTEMPTS = 3;
`else
  localparam int FAIL_ATTEMPTS = 1;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_done, tx_err;
  logic [1:0] err_code;
  logic       ps2_clk_oe, ps2_dat_oe;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;
  wire        ps2_clk_in = ~(ps2_clk_oe | dev_clk_low);
  wire        ps2_dat_in = ~(ps2_dat_oe | dev_dat_low);

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .REQ_CYCLES(RQ), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_done(tx_done), .tx_err(tx_err), .err_code(err_code),
    .ps2_clk_in(ps2_clk_in), .ps2_dat_in(ps2_dat_in),
    .ps2_clk_oe(ps2_clk_oe), .ps2_dat_oe(ps2_dat_oe)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic sb[$];

  int cyc = 0, clk_rise = 0, clk_run = 0, dat_rise = 0, acc_stamp = 0, err_stamp = 0;
  int inhibit_cnt = 0, done_cnt = 0, err_cnt = 0;
  logic prev_clk_oe = 1'b0, prev_dat_oe = 1'b0, prev_ready = 1'b0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (ps2_clk_oe && !prev_clk_oe) begin
      clk_rise = cyc;
      inhibit_cnt = inhibit_cnt + 1;
      if (prev_ready) acc_stamp = cyc;
    end
    if (!ps2_clk_oe && prev_clk_oe) clk_run = cyc - clk_rise;
    if (ps2_dat_oe && !prev_dat_oe && ps2_clk_oe) dat_rise = cyc;
    if (tx_done) done_cnt = done_cnt + 1;
    if (tx_err) begin
      err_cnt = err_cnt + 1;
      err_stamp = cyc;
    end
    prev_clk_oe = ps2_clk_oe;
    prev_dat_oe = ps2_dat_oe;
    prev_ready  = tx_ready;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_bits(input logic [7:0] d, input logic p, input int n);
    logic [10:0] fr;
    fr = {1'b1, p, d, 1'b0};
    for (int i = 0; i < n; i++) sb.push_back(fr[i]);
  endtask

  task automatic sample_bit(input int k);
    logic e;
    tests++;
    if (sb.size() == 0) begin
      fails++;
      $display("FAIL frame bit %0d: got %0d expected nothing (scoreboard empty)", k, ps2_dat_in);
    end else begin
      e = sb.pop_front();
      if (ps2_dat_in !== e) begin
        fails++;
        $display("FAIL frame bit %0d: got %0d expected %0d", k, ps2_dat_in, e);
      end
    end
    $display("[TB] device sampled bit %0d = %0d", k, ps2_dat_in);
  endtask

  // mode 0: ACK, 1: NACK, 2: stop after nbits without acknowledging
  task automatic device_frame(input int nbits, input int mode);
    int i;
    for (i = 0; i < 20000 && !ps2_clk_oe; i++) @(negedge clk);
    for (i = 0; i < 20000 && ps2_clk_oe; i++) @(negedge clk);
    if (ps2_clk_oe) begin
      check("host releases clock", 0, 1);
      return;
    end
    sample_bit(0);
    for (int k = 1; k < nbits; k++) begin
      repeat (HALF / 2) @(negedge clk);
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk);
      dev_clk_low = 1'b0;
      sample_bit(k);
    end
    if (mode < 2) begin
      repeat (HALF / 2) @(negedge clk);
      dev_dat_low = (mode == 0);
      repeat (HALF / 2) @(negedge clk);
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk);
      dev_clk_low = 1'b0;
      repeat (4) @(negedge clk);
      dev_dat_low = 1'b0;
    end
  endtask

  task automatic send_start(input logic [7:0] d, input bit hold);
    for (int i = 0; i < 20000 && !tx_ready; i++) @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    check("accept -> clk_oe", ps2_clk_oe, 1);
    if (!hold) tx_valid = 1'b0;
  endtask

  task automatic wait_result(input int d0, input int e0, input int budget);
    for (int i = 0; i < budget && done_cnt == d0 && err_cnt == e0; i++) @(negedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       nack;
    logic       parity;
    logic       exp_done;
    logic [1:0] exp_code;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int d0, e0, i0, att, lat;

    vecs[0] = '{8'hED, 1'b0, 1'b1, 1'b1, 2'b00};
    vecs[1] = '{8'h01, 1'b0, 1'b0, 1'b1, 2'b00};
    vecs[2] = '{8'h00, 1'b0, 1'b1, 1'b1, 2'b00};
    vecs[3] = '{8'hFF, 1'b0, 1'b1, 1'b1, 2'b00};
    vecs[4] = '{8'hA5, 1'b1, 1'b1, 1'b0, 2'b10};

    repeat (4) @(negedge clk);
    check("reset tx_ready", tx_ready, 1);
    check("reset tx_done", tx_done, 0);
    check("reset tx_err", tx_err, 0);
    check("reset err_code", err_code, 0);
    check("reset clk_oe", ps2_clk_oe, 0);
    check("reset dat_oe", ps2_dat_oe, 0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    for (int v = 0; v < 5; v++) begin
      d0 = done_cnt; e0 = err_cnt; i0 = inhibit_cnt;
      att = vecs[v].nack ? FAIL_ATTEMPTS : 1;
      send_start(vecs[v].data, 1'b0);
      for (int a = 0; a < att; a++) begin
        push_bits(vecs[v].data, vecs[v].parity, 11);
        device_frame(11, vecs[v].nack ? 1 : 0);
      end
      wait_result(d0, e0, 500);
      check("tx_done pulses", done_cnt - d0, int'(vecs[v].exp_done));
      check("tx_err pulses", err_cnt - e0, int'(!vecs[v].exp_done));
      check("err_code", err_code, vecs[v].exp_code);
      check("inhibit sequences", inhibit_cnt - i0, att);
      check("clk_oe low run", clk_run, INH + RQ);
      check("dat_oe rise offset", dat_rise - clk_rise, INH);
      check("lines released", {ps2_clk_oe, ps2_dat_oe}, 0);
      check("ready after frame", tx_ready, 1);
      $display("[TB] vector %0d data=%02h done=%0d err=%0d code=%0d", v, vecs[v].data,
               done_cnt - d0, err_cnt - e0, err_code);
    end

    // Device never clocks: watchdog error.
    d0 = done_cnt; e0 = err_cnt;
    send_start(8'h12, 1'b0);
    wait_result(d0, e0, FAIL_ATTEMPTS * (INH + RQ + TO) + 200);
    check("timeout tx_err", err_cnt - e0, 1);
    check("timeout err_code", err_code, 1);
    lat = err_stamp - acc_stamp;
    tests++;
    if (lat < FAIL_ATTEMPTS * (INH + RQ + TO) - 2 || lat > FAIL_ATTEMPTS * (INH + RQ + TO) + 2) begin
      fails++;
      $display("FAIL timeout latency: got %0d expected %0d +/-2", lat, FAIL_ATTEMPTS * (INH + RQ + TO));
    end
    $display("[TB] timeout latency %0d code=%0d", lat, err_code);

    // Reset after the 4th data bit.
    d0 = done_cnt; e0 = err_cnt;
    send_start(8'h3C, 1'b0);
    push_bits(8'h3C, 1'b1, 5);
    device_frame(5, 2);
    reset = 1'b1;
    @(negedge clk);
    check("midreset clk_oe", ps2_clk_oe, 0);
    check("midreset dat_oe", ps2_dat_oe, 0);
    check("midreset tx_ready", tx_ready, 1);
    reset = 1'b0;
    repeat (300) @(negedge clk);
    check("midreset no done", done_cnt - d0, 0);
    check("midreset no err", err_cnt - e0, 0);
    check("midreset err_code", err_code, 0);
    $display("[TB] mid-frame reset done");

    // tx_valid held, data changed mid-frame, back-to-back accept on tx_done.
    d0 = done_cnt; e0 = err_cnt;
    send_start(8'hF3, 1'b1);
    push_bits(8'hF3, 1'b1, 11);
    fork
      device_frame(11, 0);
      begin
        repeat (300) @(negedge clk);
        tx_data = 8'h55;
      end
    join
    for (int i = 0; i < 200 && !tx_done; i++) @(negedge clk);
    check("busy frame tx_done", tx_done, 1);
    check("done cycle tx_ready", tx_ready, 1);
    @(negedge clk);
    check("back-to-back clk_oe", ps2_clk_oe, 1);
    check("back-to-back tx_ready", tx_ready, 0);
    tx_valid = 1'b0;
    push_bits(8'h55, 1'b1, 11);
    device_frame(11, 0);
    wait_result(d0 + 1, e0, 500);
    check("second frame done", done_cnt - d0, 2);
    check("second frame no err", err_cnt - e0, 0);
    $display("[TB] back-to-back F3 then 55 complete");

    check("scoreboard drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

PS/2 host-to-device transmitter: sends one command byte (LED set 0xED, reset 0xFF, typematic 0xF3, …) from the FPGA to the keyboard over the same PS2_CLK/PS2_DAT pair that the keyboard receiver listens on. It performs the host request-to-send sequence, shifts out an 11-bit frame on device-generated clock edges, checks the device acknowledge, and reports done or error. The block drives the lines only through open-drain pull-low enables. Top level ties them off as `PS2_CLK = ps2_clk_oe ? 0 : z` and likewise for data.

## Interface
- INHIBIT_CYCLES, 5000: clocks PS2 clock is held low before the start bit (100 µs at 50 MHz).
- REQ_CYCLES, 16: clocks data and clock are both held low before clock is released.
- TIMEOUT_CYCLES, 1000000: maximum clocks between device falling edges in SEND/ACK (20 ms).

- clk  in  1  system clock, 50 MHz (CLOCK_50).
- reset  in  1  synchronous, active-high; one clock, single reset, all state synchronous to clk.
- tx_data  in  8  command byte.
- tx_valid  in  1  request; accepted only when tx_ready=1.
- tx_ready  out  1  high in IDLE.
- tx_done  out  1  one-cycle pulse: frame sent and ACK received.
- tx_err  out  1  one-cycle pulse: NACK or timeout.
- err_code  out  2  00 none, 01 timeout, 10 NACK; held until next accept.
- ps2_clk_in  in  1  raw PS2_CLK pin.
- ps2_dat_in  in  1  raw PS2_DAT pin.
- ps2_clk_oe  out  1  1 = pull PS2_CLK low.
- ps2_dat_oe  out  1  1 = pull PS2_DAT low.

## Operation
- ps2_clk_in and ps2_dat_in each pass through a 2-flop synchronizer. A falling edge (fe) is sync'd clock 1 → 0 between consecutive cycles.
- Accept: tx_valid && tx_ready. On accept, latch tx_data and parity = ~^tx_data (odd parity), clear err_code, and go to INHIBIT. tx_valid while busy is ignored and not queued.
- INHIBIT: clk_oe=1, dat_oe=0 for INHIBIT_CYCLES clocks, then go to REQ.
- REQ: clk_oe=1, dat_oe=1 (start bit 0) for REQ_CYCLES clocks. Then clk_oe=0, bit_idx=0, go to SEND, and clear the timeout counter.
- SEND: on each fe, present bit bit_idx via dat_oe = ~bit.
  - Frame order: bit_idx 0–7 are data LSB first, 8 is parity, 9 is stop (dat_oe=0).
  - bit_idx increments after each fe.
  - After the stop bit is presented, go to ACK.
- ACK: on the next fe, sample sync'd data. 0 → ACKED; 1 → err_code=10 and go to FAIL.
- ACKED: wait until both sync'd clock and data are 1. Then go to IDLE and pulse tx_done.
- FAIL: go to IDLE the following cycle and pulse tx_err.
- Timeout: in SEND/ACK/ACKED, a counter clears on every fe and increments otherwise. When it reaches TIMEOUT_CYCLES, set err_code=01, release both lines, and go to FAIL.
- Both lines are released (oe=0) in IDLE and FAIL.
- Reset mid-frame: both oe deassert on the clock after reset is sampled, state goes to IDLE, tx_done/tx_err stay 0, err_code=00, and the frame is abandoned.

## Timing
- Reset values: tx_ready=1, tx_done=0, tx_err=0, err_code=00, ps2_clk_oe=0, ps2_dat_oe=0.
- All outputs are registered.
- Accept → ps2_clk_oe=1 on the next clock.
- ps2_dat_oe goes 1 exactly INHIBIT_CYCLES clocks after clk_oe rises. clk_oe falls REQ_CYCLES clocks later.
- Pin falling edge → dat_oe update in ≤4 clocks (2 sync + edge + register). This is well inside the ~30 µs device low phase.
- tx_done/tx_err pulse in the same cycle tx_ready returns to 1. A tx_valid presented in that cycle is accepted.

## Configuration
- PS2_HOST_TX_RETRY_EN defined: on NACK or timeout, re-enter INHIBIT with the same latched byte, up to 2 retries.
  - tx_err pulses only after the third failed attempt.
  - err_code reflects the last failure.
  - tx_ready stays 0 throughout the retries.
- Not defined: the first failure reports immediately.

## Test plan
- Send 0xED; device model clocks at 12.5 kHz and ACKs. Required: clk_oe low for 5000+16 cycles. Bits sampled on device rising edges are 0, then 1,0,1,1,0,1,1,1, parity 1, stop 1. Then tx_done=1 with err_code=00.
- Send 0x01. Required: parity bit 0. Send 0x00 and 0xFF. Required: parity bit 1 for both.
- Device returns data=1 at the ACK edge. Required: tx_err pulse, err_code=10, both oe=0. With PS2_HOST_TX_RETRY_EN, three full INHIBIT sequences occur before tx_err.
- Device never clocks. Required: tx_err exactly 5016+1000000 (±2) cycles after accept, err_code=01.
- Assert reset after the 4th data bit. Required: both oe=0 and tx_ready=1 one clock later, no tx_done/tx_err pulse.
- tx_valid held high during a frame carrying 0xF3 with tx_data changed to 0x55 mid-frame. Required: frame bits are still 0xF3. The next frame starts on the tx_done cycle with 0x55.
